// File: rtl/logic_op_scheduler.sv
// Round-robin arbiter and sliced bitwise-logic engine for the ALU logic datapath.
// One W-bit AND/OR/XOR/NOR runs at a time over S cycles on an N-bit slice.
//
// state | meaning
// IDLE  | arbitrating the two requesters; REQx_R asserted for the winner
// RUN   | computing one N-bit slice of the latched operation per cycle
// DONE  | result presented on RES/RES_ID with RES_V high until RES_R
module logic_op_scheduler #(
  parameter int N = 4,
  parameter int S = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_V,
  output logic             REQ0_R,
  input  logic [1:0]       OP0,
  input  logic [N*S-1:0]   A0,
  input  logic [N*S-1:0]   B0,
  input  logic             REQ1_V,
  output logic             REQ1_R,
  input  logic [1:0]       OP1,
  input  logic [N*S-1:0]   A1,
  input  logic [N*S-1:0]   B1,
  output logic             RES_V,
  input  logic             RES_R,
  output logic [N*S-1:0]   RES,
  output logic             RES_ID,
  output logic             BUSY
);

  localparam int W  = N * S;
  localparam int KW = (S > 1) ? $clog2(S) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(S - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic            last;
  logic            id_q;
  logic [1:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    res_q;
  logic            res_v_q;
  logic            busy_q;

  logic            grant0;
  logic            grant1;
  logic [N-1:0]    a_sl;
  logic [N-1:0]    b_sl;
  logic [N-1:0]    slice_res;
  logic [W-1:0]    res_next;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant0 = REQ0_V & (~REQ1_V | last);
    grant1 = REQ1_V & (~REQ0_V | ~last);
  end

  assign REQ0_R = (state == IDLE) & ~RST & grant0;
  assign REQ1_R = (state == IDLE) & ~RST & grant1;

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < S; i++) begin
      if (k == KW'(i)) begin
        a_sl = a_q[i*N +: N];
        b_sl = b_q[i*N +: N];
      end
    end
  end

  always_comb begin
    case (op_q)
      2'b00:   slice_res = a_sl & b_sl;
      2'b01:   slice_res = a_sl | b_sl;
      2'b10:   slice_res = a_sl ^ b_sl;
      default: slice_res = ~(a_sl | b_sl);
    endcase
  end

  always_comb begin
    res_next = res_q;
    for (int i = 0; i < S; i++) begin
      if (k == KW'(i)) begin
        res_next[i*N +: N] = slice_res;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      k       <= '0;
      last    <= 1'b1;
      id_q    <= 1'b0;
      op_q    <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      res_v_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ0_R) begin
            op_q   <= OP0;
            a_q    <= A0;
            b_q    <= B0;
            id_q   <= 1'b0;
            last   <= 1'b0;
            k      <= '0;
            res_q  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else if (REQ1_R) begin
            op_q   <= OP1;
            a_q    <= A1;
            b_q    <= B1;
            id_q   <= 1'b1;
            last   <= 1'b1;
            k      <= '0;
            res_q  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res_q <= res_next;
          if (k == K_LAST) begin
            k       <= '0;
            res_v_q <= 1'b1;
            state   <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (RES_R) begin
            res_v_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          res_v_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign RES_V  = res_v_q;
  assign RES    = res_q;
  assign RES_ID = id_q;
  assign BUSY   = busy_q;

endmodule
